conv_window_pp_gen: RTL
=======================

# conv_window_pp_gen

Streaming 3x3 convolution front end that produces the nine partial products consumed by `adder_tree`. It accepts a raster-scan pixel stream, keeps a sliding 3x3 window using two line buffers, and multiplies each window pixel by a stored kernel weight. It presents the nine products with a valid/ready handshake, one window per handshake. It sits between the feature-map input stream and the `adder_tree` summation stage.

## Interface
Parameters:
- IMG_W, 28, pixels per row (>= 3)
- IMG_H, 28, rows per frame (>= 3)
- PIX_W, 8, unsigned pixel width
- WGT_W, 8, unsigned weight width; product width PP_W = PIX_W+WGT_W = 16

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame (IDLE only)
- wgt_we  in  1  weight write strobe (IDLE only)
- wgt_idx  in  4  weight index 0..8, row-major; 9..15 ignored
- wgt_data  in  WGT_W  weight value
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- pix_data  in  PIX_W  pixel, raster order
- pp_valid  out  1  partial products valid
- pp_ready  in  1  downstream accepts
- partial_product1..partial_product9  out  PP_W each  window[r][c]*w[3r+c], row-major, 1 = top-left
- busy  out  1  high in RUN
- frame_done  out  1  one-cycle pulse after last window handshake

## Operation
- Reset: state IDLE; row/col counters 0; pp_valid 0; pix_ready 0; busy 0; frame_done 0; all partial_product outputs 0; weights 0. Line buffers are not cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if wgt_we and wgt_idx <= 8, the weight at wgt_idx is written. start moves to RUN and clears the counters.
  - RUN: pix_ready = !pp_valid || pp_ready. Each accepted pixel shifts the window, is written into the line buffers, and advances col (row advances when col wraps at IDLE_W-1).
    - When the accepted pixel has row >= 2 and col >= 2, the completed window is multiplied and registered to the outputs, and pp_valid is set.
    - After the pixel at (IMG_H-1, IMG_W-1) is accepted, pix_ready stays 0. When the final pp handshake completes, the FSM moves to DONE.
  - DONE: frame_done = 1 for one cycle, then IDLE.
- In RUN and DONE, wgt_we is ignored and weights are held. start is ignored outside IDLE.
- The window columns are not valid for col < 2 of each row. No products are emitted for those positions: this is valid-mode convolution, giving (IMG_H-2)*(IMG_W-2) windows per frame.
- Arithmetic is unsigned. Products are full-width with no truncation: max 255*255 = 16'hFE01.
- Outputs hold stable while pp_valid & !pp_ready. pp_valid clears on handshake unless a new window loads in the same cycle.

## Timing
- Latency: a window-completing pixel accepted in cycle N gives pp_valid = 1 with its products in cycle N+1.
- Throughput: 1 pixel/cycle, and 1 window/cycle in steady state when pp_ready stays high.
- Simultaneous events: pp handshake and a new window-completing pixel in the same cycle reload the outputs with pp_valid kept at 1, with no bubble.
- Backpressure: pp_ready low with pp_valid high forces pix_ready low in the same cycle (combinational).
- Reset mid-frame: asynchronous return to IDLE with all outputs at their reset values. A later start begins a fresh frame, and stale line-buffer contents are never emitted.
- frame_done goes high exactly one cycle after the last pp handshake.

## Structure
- Shared package `cnn_pkg`: PIX_W/WGT_W/PP_W defaults, the FSM state enum (IDLE/RUN/DONE), and KERNEL_TAPS = 9.
- Sub-module `line_buffer`: a single-port-per-cycle delay of IMG_W pixels. Two instances are chained to produce rows r-1 and r-2. The top level holds the 3x3 shift registers, weights, multipliers and FSM.

## Test plan
- Basic window: IMG_W=IMG_H=4, all weights 1, pixels 0..15, pp_ready=1.
  - First pp set = {0,1,2,4,5,6,8,9,10} (sum 45).
  - Four windows total; frame_done pulses once, one cycle after the fourth handshake.
- Weight mapping: weights w[i]=i+1, constant pixel 2 -> partial_product1..9 = 2,4,...,18.
- Backpressure: hold pp_ready=0 for 5 cycles at the first window.
  - Outputs stay stable and pix_ready stays 0.
  - Releasing pp_ready yields the same window set with no drops or duplicates.
- Max values: pixels 255, weights 255 -> every partial_product = 16'hFE01.
- Weight write guard: wgt_we with data 7 during RUN leaves the products unchanged. wgt_idx=12 in IDLE changes no weight.
- Reset mid-frame: deassert rst_n after 6 pixels.
  - pp_valid, busy and pix_ready go to 0 immediately.
  - A new start with pixels 0..15 reproduces the basic-window results exactly.

Source files
------------

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared widths, kernel size and FSM state type for the conv front end
package cnn_pkg;
    localparam int PIX_W_DEF   = 8;
    localparam int WGT_W_DEF   = 8;
    localparam int PP_W_DEF    = PIX_W_DEF + WGT_W_DEF;
    localparam int KERNEL_TAPS = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - circular delay line of DEPTH accepted pixels
module line_buffer #(
    parameter int DEPTH  = 28,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_ptr;

    // The slot about to be overwritten holds the pixel written DEPTH enables ago.
    assign o_dout = r_mem[r_ptr];

    // Pointer walks the ring once per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    // Storage is never cleared; stale rows are flushed before any window uses them.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end
endmodule

// File: rtl/conv_window_pp_gen.sv
// rtl/conv_window_pp_gen.sv - 3x3 sliding window and per-tap weight multiply for the adder tree
module conv_window_pp_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = PIX_W_DEF,
    parameter int WGT_W = WGT_W_DEF,
    localparam int PP_W = PIX_W + WGT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             wgt_we,
    input  logic [3:0]       wgt_idx,
    input  logic [WGT_W-1:0] wgt_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pp_valid,
    input  logic             pp_ready,
    output logic [PP_W-1:0]  partial_product1,
    output logic [PP_W-1:0]  partial_product2,
    output logic [PP_W-1:0]  partial_product3,
    output logic [PP_W-1:0]  partial_product4,
    output logic [PP_W-1:0]  partial_product5,
    output logic [PP_W-1:0]  partial_product6,
    output logic [PP_W-1:0]  partial_product7,
    output logic [PP_W-1:0]  partial_product8,
    output logic [PP_W-1:0]  partial_product9,
    output logic             busy,
    output logic             frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t            r_state;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_in_done;
    logic              r_pp_valid;
    logic              r_busy;
    logic              r_frame_done;
    logic [WGT_W-1:0]  r_wgt [KERNEL_TAPS];
    logic [PP_W-1:0]   r_pp  [KERNEL_TAPS];
    logic [PIX_W-1:0]  r_win [3][2];

    logic              w_pix_acc;
    logic              w_win_done;
    logic [PIX_W-1:0]  w_lb1;
    logic [PIX_W-1:0]  w_lb2;
    logic [PIX_W-1:0]  w_col [3];
    logic [PP_W-1:0]   w_prod [KERNEL_TAPS];

    // Downstream stall blocks new pixels combinationally; nothing is taken once the frame is in.
    assign pix_ready  = (r_state == RUN) && !r_in_done && (!r_pp_valid || pp_ready);
    assign w_pix_acc  = pix_valid && pix_ready;
    assign w_win_done = w_pix_acc && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb_row1 (
        .clk(clk), .rst_n(rst_n), .i_en(w_pix_acc), .i_din(pix_data), .o_dout(w_lb1)
    );
    line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb_row2 (
        .clk(clk), .rst_n(rst_n), .i_en(w_pix_acc), .i_din(w_lb1), .o_dout(w_lb2)
    );

    // Incoming right-hand column: top from two rows up, bottom is the live pixel.
    assign w_col[0] = w_lb2;
    assign w_col[1] = w_lb1;
    assign w_col[2] = pix_data;

    // Multiply the window as it will look after this pixel, so outputs land one cycle later.
    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            w_prod[k] = '0;
        end
        for (int r = 0; r < 3; r++) begin
            w_prod[3*r]   = PP_W'(r_win[r][0]) * PP_W'(r_wgt[3*r]);
            w_prod[3*r+1] = PP_W'(r_win[r][1]) * PP_W'(r_wgt[3*r+1]);
            w_prod[3*r+2] = PP_W'(w_col[r])    * PP_W'(r_wgt[3*r+2]);
        end
    end

    // Older two window columns; the third is always the live column.
    always_ff @(posedge clk) begin
        if (w_pix_acc) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= w_col[r];
            end
        end
    end

    // Frame FSM: weight loading, raster counters, product register and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_in_done    <= 1'b0;
            r_pp_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                r_wgt[k] <= '0;
                r_pp[k]  <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_frame_done <= 1'b0;
                    if (wgt_we && (wgt_idx <= 4'd8)) begin
                        r_wgt[wgt_idx] <= wgt_data;
                    end
                    if (start) begin
                        r_state   <= RUN;
                        r_busy    <= 1'b1;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_in_done <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_pix_acc) begin
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                            if (r_row == ROW_LAST) begin
                                r_in_done <= 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                    if (w_win_done) begin
                        r_pp_valid <= 1'b1;
                        for (int k = 0; k < KERNEL_TAPS; k++) begin
                            r_pp[k] <= w_prod[k];
                        end
                    end else if (r_pp_valid && pp_ready) begin
                        r_pp_valid <= 1'b0;
                        if (r_in_done) begin
                            r_state      <= DONE;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_frame_done <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign pp_valid         = r_pp_valid;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign partial_product1 = r_pp[0];
    assign partial_product2 = r_pp[1];
    assign partial_product3 = r_pp[2];
    assign partial_product4 = r_pp[3];
    assign partial_product5 = r_pp[4];
    assign partial_product6 = r_pp[5];
    assign partial_product7 = r_pp[6];
    assign partial_product8 = r_pp[7];
    assign partial_product9 = r_pp[8];
endmodule
